// File: rtl/hit_source.sv
// hit_source: player damage producer. Samples sprite/projectile overlap once per
// frame tick and drives the `hit` level to the health bar. It also provides an
// invulnerability cooldown and a one-Clk projectile despawn pulse.
// Optional feature macro: HIT_SOURCE_SHIELD_EN. When it is defined, the block adds
// the `shield` input and the `block_count` output.
module hit_source #(
    parameter int unsigned COORD_W         = 10,
    parameter int unsigned PLAYER_SIZE     = 32,
    parameter int unsigned PROJ_SIZE       = 8,
    parameter int unsigned HOLD_FRAMES     = 4,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] proj_x,
    input  logic [COORD_W-1:0] proj_y,
    input  logic               proj_active,
`ifdef HIT_SOURCE_SHIELD_EN
    input  logic               shield,
    output logic [7:0]         block_count,
`endif
    output logic               hit,
    output logic               invuln,
    output logic               proj_consume,
    output logic [7:0]         hit_count
);

    localparam int unsigned CW    = COORD_W + 1;
    localparam int unsigned FRM_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [FRM_W-1:0] frm, frm_nxt;
    logic             hit_nxt, invuln_nxt, consume_nxt;
    logic [CNT_W-1:0] count_nxt;
`ifdef HIT_SOURCE_SHIELD_EN
    logic [CNT_W-1:0] block_nxt;
`endif

    logic fs1, fs2, fs3, tick;
    logic [CW-1:0] px, py, qx, qy;
    logic overlap_c;
    logic qualify_c;

    // Bring the raw vsync into the Clk domain and turn its rising edge into a one-Clk tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fs1  <= 1'b0;
            fs2  <= 1'b0;
            fs3  <= 1'b0;
            tick <= 1'b0;
        end else begin
            fs1  <= frame_clk;
            fs2  <= fs1;
            fs3  <= fs2;
            tick <= fs2 & ~fs3;
        end
    end

    // Widen the coordinates by one bit so that position + size never wraps.
    assign px = CW'(player_x);
    assign py = CW'(player_y);
    assign qx = CW'(proj_x);
    assign qy = CW'(proj_y);

    // Strict box intersection: boxes that only touch at an edge do not overlap.
    assign overlap_c = (px < qx + CW'(PROJ_SIZE))   && (qx < px + CW'(PLAYER_SIZE)) &&
                       (py < qy + CW'(PROJ_SIZE))   && (qy < py + CW'(PLAYER_SIZE));

    assign qualify_c = tick & proj_active & overlap_c;

    // Next-state, frame counter and next values for the registered outputs.
    always_comb begin
        state_nxt   = state;
        frm_nxt     = frm;
        consume_nxt = 1'b0;
        count_nxt   = hit_count;
`ifdef HIT_SOURCE_SHIELD_EN
        block_nxt   = block_count;
`endif
        case (state)
            ST_IDLE: begin
                if (qualify_c) begin
                    consume_nxt = 1'b1;
`ifdef HIT_SOURCE_SHIELD_EN
                    if (shield) begin
                        if (block_count != 8'hFF) begin
                            block_nxt = block_count + 8'd1;
                        end
                    end else begin
                        state_nxt = ST_ASSERT;
                        frm_nxt   = '0;
                        if (hit_count != 8'hFF) begin
                            count_nxt = hit_count + 8'd1;
                        end
                    end
`else
                    state_nxt = ST_ASSERT;
                    frm_nxt   = '0;
                    if (hit_count != 8'hFF) begin
                        count_nxt = hit_count + 8'd1;
                    end
`endif
                end
            end
            ST_ASSERT: begin
                if (tick) begin
                    if (frm == FRM_W'(HOLD_FRAMES - 1)) begin
                        state_nxt = ST_COOLDOWN;
                        frm_nxt   = '0;
                    end else begin
                        frm_nxt = frm + 8'd1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (frm == FRM_W'(COOLDOWN_FRAMES - 1)) begin
                        state_nxt = ST_IDLE;
                        frm_nxt   = '0;
                    end else begin
                        frm_nxt = frm + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                frm_nxt   = '0;
            end
        endcase
        hit_nxt    = (state_nxt == ST_ASSERT);
        invuln_nxt = (state_nxt == ST_COOLDOWN);
    end

    // State, frame counter and Moore outputs, all cleared immediately by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            frm          <= '0;
            hit          <= 1'b0;
            invuln       <= 1'b0;
            proj_consume <= 1'b0;
            hit_count    <= '0;
`ifdef HIT_SOURCE_SHIELD_EN
            block_count  <= '0;
`endif
        end else begin
            state        <= state_nxt;
            frm          <= frm_nxt;
            hit          <= hit_nxt;
            invuln       <= invuln_nxt;
            proj_consume <= consume_nxt;
            hit_count    <= count_nxt;
`ifdef HIT_SOURCE_SHIELD_EN
            block_count  <= block_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_hit_source.sv
// tb_hit_source: randomized and directed frame stimulus for hit_source.
// A frame-level reference model queues the expected hit/invuln state after each
// tick and the expected hit_count at each despawn pulse; independent monitors
// compare these against the DUT outputs.
module tb_hit_source;

    localparam int unsigned CW   = 10;
    localparam int          PS   = 32;
    localparam int          QS   = 8;
    localparam int          HOLD = 4;
    localparam int          COOL = 30;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_clk = 1'b0;
    logic [CW-1:0] player_x = '0, player_y = '0, proj_x = '0, proj_y = '0;
    logic          proj_active = 1'b0;
    logic          hit, invuln, proj_consume;
    logic [7:0]    hit_count;
`ifdef HIT_SOURCE_SHIELD_EN
    logic          shield = 1'b0;
    logic [7:0]    block_count;
`endif

    hit_source #(
        .COORD_W(CW), .PLAYER_SIZE(PS), .PROJ_SIZE(QS),
        .HOLD_FRAMES(HOLD), .COOLDOWN_FRAMES(COOL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .player_x(player_x), .player_y(player_y),
        .proj_x(proj_x), .proj_y(proj_y), .proj_active(proj_active),
`ifdef HIT_SOURCE_SHIELD_EN
        .shield(shield), .block_count(block_count),
`endif
        .hit(hit), .invuln(invuln), .proj_consume(proj_consume),
        .hit_count(hit_count)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    int       consume_q[$];
    bit [1:0] frame_q[$];

    // Frame-level model: age = frames since the last strike, -1 when ready.
    int age    = -1;
    int mcount = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic model_frame(input int ppx, input int ppy, input int qqx, input int qqy,
                               input bit act);
        bit ov;
        ov = (ppx < qqx + QS) && (qqx < ppx + PS) && (ppy < qqy + QS) && (qqy < ppy + PS);
        if (age < 0) begin
            if (act && ov) begin
                age = 0;
                if (mcount < 255) mcount++;
                consume_q.push_back(mcount);
            end
        end else begin
            age++;
            if (age == HOLD + COOL) age = -1;
        end
        frame_q.push_back({(age >= 0 && age < HOLD), (age >= HOLD)});
    endtask

    // One frame of 6 Clk: raw vsync high for 3 Clk, low for 3 Clk.
    task automatic frame(input int ppx, input int ppy, input int qqx, input int qqy,
                         input bit act);
        @(negedge Clk);
        player_x    = CW'(ppx);
        player_y    = CW'(ppy);
        proj_x      = CW'(qqx);
        proj_y      = CW'(qqy);
        proj_active = act;
        model_frame(ppx, ppy, qqx, qqy, act);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) frame(100, 100, 600, 600, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("reset_hit", int'(hit), 0);
        chk("reset_invuln", int'(invuln), 0);
        chk("reset_consume", int'(proj_consume), 0);
        chk("reset_count", int'(hit_count), 0);
        age    = -1;
        mcount = 0;
        consume_q.delete();
        frame_q.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Frame monitor: the DUT updates 4 Clk after the raw vsync edge, and the
    // monitor samples the outputs at that point.
    initial begin
        forever begin
            @(posedge frame_clk);
            repeat (4) @(negedge Clk);
            if (frame_q.size() == 0) begin
                chk("frame_queue_empty", 1, 0);
            end else begin
                bit [1:0] e;
                e = frame_q.pop_front();
                chk("hit", int'(hit), int'(e[1]));
                chk("invuln", int'(invuln), int'(e[0]));
            end
        end
    end

    // Despawn monitor: every proj_consume pulse must match a predicted strike.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset && proj_consume) begin
                if (consume_q.size() == 0) begin
                    chk("unexpected_consume", 1, 0);
                end else begin
                    chk("count_at_consume", int'(hit_count), consume_q.pop_front());
                end
            end
        end
    end

    // Pulse width: the despawn pulse must never last two Clk.
    initial begin
        forever begin
            @(negedge Clk);
            if (proj_consume) begin
                @(negedge Clk);
                if (proj_consume) chk("consume_width", 2, 1);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int px, py, qx, qy;
        apply_reset();
        repeat (3) @(negedge Clk);

        // Basic strike, then a full hold and cooldown with no projectile.
        frame(100, 100, 120, 110, 1'b1);
        idle_frames(36);
        chk("count_after_first", int'(hit_count), 1);

        // Edge touching on each side is not a hit; one pixel inside is.
        frame(100, 100, 132, 100, 1'b1);
        frame(100, 100, 100, 132, 1'b1);
        frame(100, 100, 92, 100, 1'b1);
        frame(100, 100, 100, 92, 1'b1);
        chk("count_edge_touch", int'(hit_count), 1);
        frame(100, 100, 131, 100, 1'b1);
        idle_frames(36);
        chk("count_one_inside", int'(hit_count), 2);

        // Overlap without an active projectile is not a hit.
        frame(100, 100, 110, 110, 1'b0);
        chk("count_inactive", int'(hit_count), 2);

        // Overlap held for 40 frames: a second strike only after the cooldown.
        for (int i = 0; i < 40; i++) frame(200, 200, 210, 215, 1'b1);
        idle_frames(36);
        chk("count_held", int'(hit_count), 4);

        // Reset during the hold phase, then strike again from a fresh count.
        frame(100, 100, 120, 110, 1'b1);
        frame(100, 100, 600, 600, 1'b0);
        frame(100, 100, 600, 600, 1'b0);
        chk("hit_before_reset", int'(hit), 1);
        apply_reset();
        frame(100, 100, 120, 110, 1'b1);
        idle_frames(36);
        chk("count_after_reset", int'(hit_count), 1);

        // Random frames near the player, including the far screen corner.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                px = $urandom_range(990, 1023);
                py = $urandom_range(990, 1023);
                qx = $urandom_range(980, 1023);
                qy = $urandom_range(980, 1023);
            end else begin
                px = $urandom_range(300, 320);
                py = $urandom_range(300, 320);
                qx = $urandom_range(270, 360);
                qy = $urandom_range(270, 360);
            end
            frame(px, py, qx, qy, 1'($urandom_range(0, 1)));
        end
        idle_frames(36);

        // Saturation: 260 strikes from a fresh count.
        apply_reset();
        for (int i = 0; i < 260 * (HOLD + COOL + 1); i++) frame(500, 500, 510, 510, 1'b1);
        idle_frames(36);
        chk("count_saturated", int'(hit_count), 255);

        repeat (10) @(negedge Clk);
        chk("pending_consume", consume_q.size(), 0);
        chk("pending_frames", frame_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
